dyser_recv_port: RTL and testbench

- Core-facing responder for the dyser_recv protocol. The core drives recv_port/recv_en on two lanes; this block returns recv_data and recv_stall.
- Holds one FIFO per DySER output port. Each FIFO is filled by the fabric's output switches through a valid/ready handshake.
- Sits between the fabric output edge and the core's recv lanes. It is the counterpart of the send-side input interface.

---
 rtl/dyser_recv_port_if.sv | 36 +++
 rtl/dyser_recv_port.sv | 140 ++++++++++++++
 tb/tb_dyser_recv_port.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dyser_recv_port_if.sv
// Bundle of the fabric-facing fill handshake and the core-facing dual recv lanes.
// The master is whoever drives fabric data and core requests; the slave is the recv port.
interface dyser_recv_port_if #(
  parameter int DW     = 64,
  parameter int NPORTS = 8
) ();
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  // Fill side: a word on port p transfers at posedge when fab_valid[p] && fab_ready[p].
  // fab_ready depends on registered occupancy only; fab_valid must not wait on fab_ready.
  logic [NPORTS-1:0]    fab_valid;
  logic [NPORTS*DW-1:0] fab_data;
  logic [NPORTS-1:0]    fab_ready;

  logic [PW-1:0] recv_port_r0;
  logic [PW-1:0] recv_port_r1;
  logic          recv_en0;
  logic          recv_en1;
  logic [DW-1:0] recv_data_r0;
  logic [DW-1:0] recv_data_r1;
  logic          recv_stall;

  modport master (
    output fab_valid, fab_data,
    input  fab_ready,
    output recv_port_r0, recv_port_r1, recv_en0, recv_en1,
    input  recv_data_r0, recv_data_r1, recv_stall
  );

  modport slave (
    input  fab_valid, fab_data,
    output fab_ready,
    input  recv_port_r0, recv_port_r1, recv_en0, recv_en1,
    output recv_data_r0, recv_data_r1, recv_stall
  );
endinterface

// File: rtl/dyser_recv_port.sv
// Per-output-port FIFOs filled by the fabric and drained by the core's two recv lanes.
// Reads are zero-latency from the FIFO heads; pops are all-or-nothing across both lanes.
module dyser_recv_port #(
  parameter int DW     = 64,
  parameter int NPORTS = 8,
  parameter int DEPTH  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  dyser_recv_port_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [DW-1:0] mem_q    [NPORTS][DEPTH];
  logic [AW-1:0] rd_ptr_q [NPORTS];
  logic [AW-1:0] rd_ptr_d [NPORTS];
  logic [AW-1:0] wr_ptr_q [NPORTS];
  logic [AW-1:0] wr_ptr_d [NPORTS];
  logic [CW-1:0] cnt_q    [NPORTS];
  logic [CW-1:0] cnt_d    [NPORTS];

  logic [NPORTS-1:0] not_full;
  logic [NPORTS-1:0] push;
  logic [1:0]        npop [NPORTS];

  logic [PW-1:0] port0, port1;
  logic          en0, en1;
  logic [CW-1:0] cnt0, cnt1;
  logic [AW-1:0] head0_ptr, head1_ptr, next1_ptr;
  logic          same_port;
  logic          stall_raw;
  logic [DW-1:0] data0_raw, data1_raw;

  assign port0 = bus.recv_port_r0;
  assign port1 = bus.recv_port_r1;
  assign en0   = bus.recv_en0;
  assign en1   = bus.recv_en1;

  assign cnt0      = cnt_q[port0];
  assign cnt1      = cnt_q[port1];
  assign head0_ptr = rd_ptr_q[port0];
  assign head1_ptr = rd_ptr_q[port1];
  assign next1_ptr = rd_ptr_q[port1] + AW'(1);
  assign same_port = en0 && en1 && (port0 == port1);

  assign stall_raw = (en0 && (cnt0 == '0)) ||
                     (en1 && (cnt1 == '0)) ||
                     (same_port && (cnt0 < CW'(2)));

  always_comb begin
    data0_raw = '0;
    data1_raw = '0;
    if (en0 && (cnt0 != '0)) begin
      data0_raw = mem_q[port0][head0_ptr];
    end
    // A same-port dual request hands lane 1 the entry behind the head.
    if (same_port) begin
      if (cnt1 >= CW'(2)) begin
        data1_raw = mem_q[port1][next1_ptr];
      end
    end else if (en1 && (cnt1 != '0)) begin
      data1_raw = mem_q[port1][head1_ptr];
    end
  end

  // Core-facing outputs are forced quiet while reset is held.
  assign bus.recv_stall   = rst && stall_raw;
  assign bus.recv_data_r0 = rst ? data0_raw : '0;
  assign bus.recv_data_r1 = rst ? data1_raw : '0;

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      not_full[p] = (cnt_q[p] != CW'(DEPTH));
    end
  end

  assign bus.fab_ready = rst ? not_full : '1;
  assign push          = bus.fab_valid & not_full;

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      npop[p] = 2'd0;
      if (!stall_raw) begin
        if (en0 && (port0 == PW'(p))) npop[p] = npop[p] + 2'd1;
        if (en1 && (port1 == PW'(p))) npop[p] = npop[p] + 2'd1;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      cnt_d[p]    = cnt_q[p] + CW'(push[p]) - CW'(npop[p]);
      rd_ptr_d[p] = rd_ptr_q[p] + AW'(npop[p]);
      wr_ptr_d[p] = wr_ptr_q[p] + AW'(push[p]);
      if (flush) begin
        cnt_d[p]    = '0;
        rd_ptr_d[p] = '0;
        wr_ptr_d[p] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NPORTS; p++) begin
        cnt_q[p]    <= '0;
        rd_ptr_q[p] <= '0;
        wr_ptr_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        cnt_q[p]    <= cnt_d[p];
        rd_ptr_q[p] <= rd_ptr_d[p];
        wr_ptr_q[p] <= wr_ptr_d[p];
      end
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORTS; p++) begin
      if (push[p] && !flush && rst) begin
        mem_q[p][wr_ptr_q[p]] <= bus.fab_data[p*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NPORTS; p++) begin
        assert (cnt_q[p] <= CW'(DEPTH));
        assert ({1'b0, npop[p]} <= 3'(cnt_q[p]));
      end
    end
  end

endmodule

// File: tb/tb_dyser_recv_port.sv
// Bench for dyser_recv_port: directed scenarios then random traffic, all checked
// against per-port queues that model the FIFOs directly.
module tb_dyser_recv_port;
  localparam int DW    = 64;
  localparam int NP    = 8;
  localparam int DEPTH = 2;

  logic clk;
  logic rst;
  logic flush;

  dyser_recv_port_if #(.DW(DW), .NPORTS(NP)) bus ();

  dyser_recv_port #(.DW(DW), .NPORTS(NP), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q [NP][$];
  int total;
  int bad;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int p = 0; p < NP; p++) exp_q[p].delete();
  endtask

  // ---------------- drivers ----------------
  task automatic clr_in();
    bus.fab_valid    = '0;
    bus.fab_data     = '0;
    bus.recv_en0     = 1'b0;
    bus.recv_en1     = 1'b0;
    bus.recv_port_r0 = '0;
    bus.recv_port_r1 = '0;
    flush            = 1'b0;
  endtask

  task automatic drv_push(input int p, input logic [DW-1:0] d);
    bus.fab_valid[p]          = 1'b1;
    bus.fab_data[p*DW +: DW]  = d;
  endtask

  task automatic drv_recv(input bit e0, input int p0, input bit e1, input int p1);
    bus.recv_en0     = e0;
    bus.recv_port_r0 = 3'(p0);
    bus.recv_en1     = e1;
    bus.recv_port_r1 = 3'(p1);
  endtask

  // One clock with the current inputs: check outputs at negedge, then advance the model.
  task automatic tick();
    logic [NP-1:0] e_rdy;
    logic [NP-1:0] acc;
    logic [NP*DW-1:0] pdata;
    logic e_stall, same, e0, e1, fl;
    logic [DW-1:0] d0, d1;
    int p0, p1, s0, s1;
    @(negedge clk);
    for (int p = 0; p < NP; p++) e_rdy[p] = (exp_q[p].size() != DEPTH);
    p0 = int'(bus.recv_port_r0);
    p1 = int'(bus.recv_port_r1);
    e0 = bus.recv_en0;
    e1 = bus.recv_en1;
    s0 = exp_q[p0].size();
    s1 = exp_q[p1].size();
    same = e0 && e1 && (p0 == p1);
    e_stall = (e0 && s0 == 0) || (e1 && s1 == 0) || (same && s0 < 2);
    d0 = (e0 && s0 >= 1) ? exp_q[p0][0] : '0;
    if (same) d1 = (s1 >= 2) ? exp_q[p1][1] : '0;
    else      d1 = (e1 && s1 >= 1) ? exp_q[p1][0] : '0;
    check_val("ready", DW'(bus.fab_ready), DW'(e_rdy));
    check_val("stall", DW'(bus.recv_stall), DW'(e_stall));
    check_val("r0", bus.recv_data_r0, d0);
    check_val("r1", bus.recv_data_r1, d1);
    acc   = bus.fab_valid & e_rdy;
    pdata = bus.fab_data;
    fl    = flush;
    @(posedge clk);
    #1;
    if (fl) begin
      model_clear();
    end else begin
      if (!e_stall) begin
        if (e0) void'(exp_q[p0].pop_front());
        if (e1) void'(exp_q[p1].pop_front());
      end
      for (int p = 0; p < NP; p++)
        if (acc[p]) exp_q[p].push_back(pdata[p*DW +: DW]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    clr_in();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready", DW'(bus.fab_ready), DW'(8'hff));
    check_val("rst_stall", DW'(bus.recv_stall), '0);
    drv_recv(1, 3, 1, 3);
    #1;
    check_val("rst_stall_en", DW'(bus.recv_stall), '0);
    check_val("rst_r0", bus.recv_data_r0, '0);
    clr_in();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic read on two ports
    drv_push(6, 64'h0); drv_push(4, 64'h1); tick(); clr_in();
    drv_recv(1, 6, 1, 4); tick(); clr_in();
    drv_recv(1, 6, 1, 4); tick(); clr_in();

    // 2: empty stall, then fill releases the held request one cycle later
    drv_recv(1, 2, 0, 0); tick();
    drv_push(2, 64'h2); tick();
    bus.fab_valid = '0; tick();
    tick(); clr_in();

    // 3: full backpressure with a held valid
    drv_push(1, 64'h4); tick();
    drv_push(1, 64'h5); tick();
    drv_push(1, 64'h6); tick();
    drv_recv(1, 1, 0, 0); tick();
    bus.recv_en0 = 1'b0; tick(); clr_in();
    drv_recv(1, 1, 0, 0); tick(); tick(); tick(); clr_in();

    // 4: same-port dual recv, then with a single entry
    drv_push(3, 64'hA); tick(); drv_push(3, 64'hB); tick(); clr_in();
    drv_recv(1, 3, 1, 3); tick(); clr_in();
    drv_push(3, 64'hA); tick(); clr_in();
    drv_recv(1, 3, 1, 3); tick(); tick(); clr_in();
    drv_recv(1, 3, 0, 0); tick(); clr_in();

    // 5: partial stall is atomic
    drv_push(5, 64'h7); tick(); clr_in();
    drv_recv(1, 5, 1, 0); tick(); clr_in();
    drv_recv(1, 5, 0, 0); tick(); clr_in();

    // 6: flush with three ports occupied, then async reset with port 1 full
    drv_push(0, 64'h10); drv_push(1, 64'h11); drv_push(2, 64'h12); tick();
    drv_push(1, 64'h13); drv_push(1, 64'h13); tick(); clr_in();
    flush = 1'b1; drv_push(7, 64'h77); drv_recv(1, 0, 0, 0); tick(); clr_in();
    drv_recv(1, 0, 1, 1); tick(); drv_recv(1, 2, 0, 0); tick(); clr_in();
    drv_push(1, 64'h20); tick(); drv_push(1, 64'h21); tick(); clr_in();
    check_val("full_before_rst", DW'(bus.fab_ready[1]), '0);
    #2;
    rst = 1'b0;
    #1;
    check_val("async_rst_ready", DW'(bus.fab_ready), DW'(8'hff));
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    drv_recv(1, 1, 0, 0); tick(); clr_in();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      clr_in();
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 2) == 0) drv_push(p, {$urandom, $urandom});
      end
      drv_recv($urandom_range(0, 1) == 1, $urandom_range(0, NP - 1),
               $urandom_range(0, 1) == 1, $urandom_range(0, NP - 1));
      if ($urandom_range(0, 3) == 0) bus.recv_port_r1 = bus.recv_port_r0;
      flush = ($urandom_range(0, 40) == 0);
      tick();
    end
    clr_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
